spi_word_monitor: RTL
=====================

Name: spi_word_monitor

Overview:
- Multi-channel SPI debug transmitter. Streams internal words (PC, bus values, etc.) off-chip to a logic analyser or MCU.
- Generalises the single-purpose program-counter SPI output of the soc: parametrised word width, channel count, clock divider and bit order.
- Each channel has its own chip select, so the receiver can tell which source a word came from.
- Adds a per-channel one-word holding buffer, round-robin arbitration and an optional change-only mode that suppresses repeated values.
- Sits in the soc next to the core. Drives the shared spi_sck and spi_mosi pins and the per-channel spi_cs_n pins.

Parameters:
- WIDTH, 32: bits per word; must be 2 or more.
- CHANNELS, 2: number of sources / chip selects; 1 to 8.
- CLK_DIV, 4: clk cycles per SCK half-period; 1 or more.
- GAP, 2: half-periods with all CS high between frames; 1 or more.
- MSB_FIRST, 1: 1 shifts out bit WIDTH-1 first, 0 shifts out bit 0 first.
- CHANGE_ONLY, 0: 1 drops a word equal to the last word accepted on that channel.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- ch_valid  in  CHANNELS  per-channel word offered.
- ch_data  in  CHANNELS*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- ch_ready  out  CHANNELS  per-channel holding buffer is free.
- busy  out  1  a frame or inter-frame gap is in progress.
- spi_sck  out  1  SPI clock, mode 0 (idles low).
- spi_mosi  out  1  serial data.
- spi_cs_n  out  CHANNELS  active-low chip selects; at most one is low at any time.

Behaviour:
- Reset: everything clears asynchronously. Outputs: spi_sck=0, spi_mosi=0, spi_cs_n all 1, ch_ready all 1, busy=0.
- Reset internals: pending flags 0, last-word-valid flags 0, round-robin pointer set so channel 0 has highest priority, FSM in IDLE.
- Reset asserted mid-frame aborts the frame at once. No partial completion.
- Handshake:
  - ch_ready[i] = !pending[i].
  - A transfer on ch_valid[i] & ch_ready[i] latches ch_data into hold[i] and sets pending[i].
- CHANGE_ONLY=1:
  - The transfer is still accepted (ready stays asserted), but pending is not set if the last-word-valid flag is set and the word equals last[i].
  - last[i] updates on every accepted word.
- Half-period tick: a divider counter runs only outside IDLE and pulses once every CLK_DIV cycles. With CLK_DIV=1 it pulses every cycle.
- FSM states: IDLE, SETUP, SHIFT_HI, SHIFT_LO, GAP.
- IDLE:
  - If any pending bit is set, grant the first pending channel searching upward from ptr and wrapping modulo CHANNELS.
  - On grant: copy hold[g] to the shift register, clear pending[g], set ptr=g+1 (wraps), drive spi_cs_n[g] low, drive spi_mosi with the first bit, set busy=1, go to SETUP.
  - pending[g] clears in the same cycle as the grant; ch_ready[g] rises the next cycle.
  - A grant and a new transfer on another channel in the same cycle are independent.
- SETUP: lasts 1 half-period with spi_sck=0, then go to SHIFT_HI.
- SHIFT_HI: spi_sck=1 for 1 half-period; the receiver samples on this rising edge. Then go to SHIFT_LO.
- SHIFT_LO:
  - spi_sck=0 for 1 half-period.
  - At its end, if bits remain, advance spi_mosi to the next bit and return to SHIFT_HI.
  - After WIDTH bits, raise spi_cs_n, set spi_mosi=0, go to GAP.
- GAP: GAP half-periods with all CS high, then go to IDLE; busy=0 in IDLE.
- Frame timing: CS low for exactly (1+2*WIDTH)*CLK_DIV clk cycles with exactly WIDTH rising SCK edges. Minimum frame-start spacing is (1+2*WIDTH+GAP)*CLK_DIV+1 cycles.
- Data arriving while a frame is in progress is buffered in hold[]. A channel can hold 1 word plus 1 in flight. ch_valid stays blocked until its pending word is granted.

Test Plan:
- Single word (CHANNELS=2, WIDTH=32, CLK_DIV=2): ch0 sends 0x6D73E55F -> spi_cs_n[0] low for 130 cycles, 32 rising edges, sampled bits give 0x6D73E55F MSB first, spi_cs_n[1] stays high, busy falls after the gap.
- Arbitration: ch0=0xB11A8EE1 and ch1=0x1F2E3D4C offered in the same cycle after reset -> ch0 frame first, then ch1. Next simultaneous pair -> ch0 again (ptr wrapped). Never two CS low at once.
- Back-pressure: three words 0x1, 0x2, 0x3 on ch0 back-to-back -> 0x1 in flight, 0x2 held, ch_ready[0]=0 until 0x2 is granted; all three frames are transmitted in order.
- Change-only (CHANGE_ONLY=1): ch0 sends 0x100, 0x100, 0x104 -> exactly two frames, 0x100 then 0x104. After reset, 0x0 is still transmitted.
- LSB-first / divider (MSB_FIRST=0, CLK_DIV=1, WIDTH=8): send 0xA5 -> bit sequence 1,0,1,0,0,1,0,1 and CS low for 17 cycles.
- Reset mid-frame: assert rst_n=0 after 10 SCK edges -> same cycle spi_cs_n all 1, spi_sck=0, ch_ready all 1. After release, a new word is transmitted complete.

Source files
------------

// File: rtl/spi_word_monitor_if.sv
// Bundle of the per-channel word handshake and the SPI pins for spi_word_monitor.
// The master side offers words and watches the pins; the slave side is the monitor.
interface spi_word_monitor_if #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 2
);
    logic [CHANNELS-1:0]       ch_valid;
    logic [CHANNELS*WIDTH-1:0] ch_data;
    logic [CHANNELS-1:0]       ch_ready;
    logic                      busy;
    logic                      spi_sck;
    logic                      spi_mosi;
    logic [CHANNELS-1:0]       spi_cs_n;

    modport master (
        output ch_valid, ch_data,
        input  ch_ready, busy, spi_sck, spi_mosi, spi_cs_n
    );

    modport slave (
        input  ch_valid, ch_data,
        output ch_ready, busy, spi_sck, spi_mosi, spi_cs_n
    );
endinterface

// File: rtl/spi_word_monitor.sv
// Multi-channel SPI debug transmitter: one holding word per channel, round-robin
// grant, one chip select per channel, SPI mode 0, optional change-only filter.

// Per-channel holding buffer with optional repeat suppression.
module spi_word_monitor_chan #(
    parameter int WIDTH       = 32,
    parameter int CHANGE_ONLY = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid,
    input  logic [WIDTH-1:0] data,
    input  logic             clr,
    output logic             ready,
    output logic             pending,
    output logic [WIDTH-1:0] hold
);
    logic [WIDTH-1:0] last;
    logic             last_vld;
    logic             accept;
    logic             repeat_word;

    assign ready       = !pending;
    assign accept      = valid && !pending;
    assign repeat_word = (CHANGE_ONLY != 0) && last_vld && (data == last);

    // Latch accepted words; a repeated word is taken but not queued for sending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending  <= 1'b0;
            hold     <= '0;
            last     <= '0;
            last_vld <= 1'b0;
        end else begin
            if (clr)
                pending <= 1'b0;
            if (accept) begin
                hold     <= data;
                last     <= data;
                last_vld <= 1'b1;
                if (!repeat_word)
                    pending <= 1'b1;
            end
        end
    end
endmodule

module spi_word_monitor #(
    parameter int WIDTH       = 32,
    parameter int CHANNELS    = 2,
    parameter int CLK_DIV     = 4,
    parameter int GAP         = 2,
    parameter int MSB_FIRST   = 1,
    parameter int CHANGE_ONLY = 0
) (
    input logic               clk,
    input logic               rst_n,
    spi_word_monitor_if.slave bus
);
    localparam int PW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(WIDTH);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_SETUP    = 3'd1;
    localparam logic [2:0] ST_SHIFT_HI = 3'd2;
    localparam logic [2:0] ST_SHIFT_LO = 3'd3;
    localparam logic [2:0] ST_GAP      = 3'd4;

    logic [2:0]                      state;
    logic [DW-1:0]                   div_cnt;
    logic                            tick;
    logic [BW-1:0]                   bit_cnt;
    logic [GW-1:0]                   gap_cnt;
    logic [WIDTH-1:0]                sreg;
    logic                            sck_q;
    logic                            mosi_q;
    logic [CHANNELS-1:0]             cs_n_q;
    logic [PW-1:0]                   ptr;
    logic [CHANNELS-1:0]             pending;
    logic [CHANNELS-1:0]             clr;
    logic [CHANNELS-1:0][WIDTH-1:0]  hold;
    logic                            gnt_vld;
    logic [PW-1:0]                   gnt_idx;
    logic [PW-1:0]                   ptr_nxt;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        spi_word_monitor_chan #(
            .WIDTH       (WIDTH),
            .CHANGE_ONLY (CHANGE_ONLY)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .valid   (bus.ch_valid[i]),
            .data    (bus.ch_data[i*WIDTH +: WIDTH]),
            .clr     (clr[i]),
            .ready   (bus.ch_ready[i]),
            .pending (pending[i]),
            .hold    (hold[i])
        );
    end

    // First pending channel at or above ptr, wrapping around.
    always_comb begin
        logic [PW-1:0] idx;
        idx     = '0;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            idx = PW'((int'(ptr) + k) % CHANNELS);
            if (!gnt_vld && pending[idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = idx;
            end
        end
    end

    assign ptr_nxt = (gnt_idx == PW'(CHANNELS - 1)) ? '0 : gnt_idx + 1'b1;
    assign clr     = (state == ST_IDLE && gnt_vld) ? (CHANNELS'(1) << gnt_idx) : '0;
    assign tick    = (state != ST_IDLE) && (div_cnt == DW'(CLK_DIV - 1));

    assign bus.busy     = (state != ST_IDLE);
    assign bus.spi_sck  = sck_q;
    assign bus.spi_mosi = mosi_q;
    assign bus.spi_cs_n = cs_n_q;

    // Half-period divider, held at zero while idle so every frame starts aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            div_cnt <= '0;
        else if (state == ST_IDLE || tick)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + 1'b1;
    end

    // Frame sequencer: grant, setup half-period, WIDTH sck pulses, then the gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            bit_cnt <= '0;
            gap_cnt <= '0;
            sreg    <= '0;
            sck_q   <= 1'b0;
            mosi_q  <= 1'b0;
            cs_n_q  <= '1;
            ptr     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (gnt_vld) begin
                        sreg    <= hold[gnt_idx];
                        mosi_q  <= (MSB_FIRST != 0) ? hold[gnt_idx][WIDTH-1] : hold[gnt_idx][0];
                        cs_n_q  <= ~(CHANNELS'(1) << gnt_idx);
                        ptr     <= ptr_nxt;
                        bit_cnt <= '0;
                        state   <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    if (tick) begin
                        sck_q <= 1'b1;
                        state <= ST_SHIFT_HI;
                    end
                end
                ST_SHIFT_HI: begin
                    if (tick) begin
                        sck_q <= 1'b0;
                        state <= ST_SHIFT_LO;
                    end
                end
                ST_SHIFT_LO: begin
                    if (tick) begin
                        if (bit_cnt == BW'(WIDTH - 1)) begin
                            cs_n_q  <= '1;
                            mosi_q  <= 1'b0;
                            gap_cnt <= '0;
                            state   <= ST_GAP;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            if (MSB_FIRST != 0) begin
                                sreg   <= {sreg[WIDTH-2:0], 1'b0};
                                mosi_q <= sreg[WIDTH-2];
                            end else begin
                                sreg   <= {1'b0, sreg[WIDTH-1:1]};
                                mosi_q <= sreg[1];
                            end
                            sck_q <= 1'b1;
                            state <= ST_SHIFT_HI;
                        end
                    end
                end
                ST_GAP: begin
                    if (tick) begin
                        if (gap_cnt == GW'(GAP - 1))
                            state <= ST_IDLE;
                        else
                            gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
